liteic_slave_write_arbiter: RTL and testbench

//  Round-robin grant controller for one slave node's AXI-Lite write path in the liteic crossbar.

---
 rtl/liteic_pkg.sv | 12 +
 rtl/liteic_rr_pick.sv | 31 +++
 rtl/liteic_slave_write_arbiter.sv | 128 ++++++++++++
 tb/tb_liteic_slave_write_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/liteic_pkg.sv
// Shared types and defaults for the liteic crossbar node arbiters.
package liteic_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_RESP
    } liteic_arb_state_e;

    localparam int IC_WR_ARB_TIMEOUT = 256;

endpackage

// File: rtl/liteic_rr_pick.sv
// Rotating-priority picker: the first set request strictly after ptr (mod NUM_REQ) wins.
module liteic_rr_pick #(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  onehot,
    output logic [ID_WIDTH-1:0] id,
    output logic                any
);

    logic [ID_WIDTH-1:0] idx;

    // The scan ends on ptr itself, so the previous owner has the lowest priority.
    always_comb begin
        onehot = '0;
        id     = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                onehot[idx] = 1'b1;
                id          = idx;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/liteic_slave_write_arbiter.sv
// Round-robin write-path owner for one slave node: holds a grant across AW+W+B
// and opens each channel mux only while that channel is still expected.
module liteic_slave_write_arbiter
    import liteic_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = IC_WR_ARB_TIMEOUT,
    localparam int ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic                aw_hs_i,
    input  logic                w_hs_i,
    input  logic                b_hs_i,
    output logic [NUM_REQ-1:0]  grant_onehot_o,
    output logic [ID_WIDTH-1:0] grant_id_o,
    output logic                grant_val_o,
    output logic                aw_open_o,
    output logic                w_open_o,
    output logic                b_open_o,
    output logic                err_timeout_o,
    output logic                err_proto_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    liteic_arb_state_e   state;
    logic [ID_WIDTH-1:0] ptr_r;
    logic                aw_done_r;
    logic                w_done_r;
    logic [CNT_W-1:0]    wd_cnt_r;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [ID_WIDTH-1:0] pick_id;
    logic                pick_any;
    logic                aw_done_nxt;
    logic                w_done_nxt;
    logic [CNT_W-1:0]    wd_next;
    logic                wd_hit;
    logic                proto_hit;

    liteic_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_i),
        .ptr    (ptr_r),
        .onehot (pick_onehot),
        .id     (pick_id),
        .any    (pick_any)
    );

    // A zero limit leaves the counter parked at 0 and never raises the flag.
    always_comb begin
        aw_done_nxt = aw_done_r | aw_hs_i;
        w_done_nxt  = w_done_r | w_hs_i;
        wd_next     = (wd_cnt_r == WD_LIMIT) ? wd_cnt_r : wd_cnt_r + CNT_W'(1);
        wd_hit      = (TIMEOUT_CYCLES != 0) && (wd_next == WD_LIMIT);
        proto_hit   = (aw_hs_i && !aw_open_o) || (w_hs_i && !w_open_o) || (b_hs_i && !b_open_o);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state          <= ARB_IDLE;
            ptr_r          <= ID_WIDTH'(NUM_REQ - 1);
            grant_onehot_o <= '0;
            grant_id_o     <= '0;
            grant_val_o    <= 1'b0;
            aw_open_o      <= 1'b0;
            w_open_o       <= 1'b0;
            b_open_o       <= 1'b0;
            aw_done_r      <= 1'b0;
            w_done_r       <= 1'b0;
            wd_cnt_r       <= '0;
            err_timeout_o  <= 1'b0;
            err_proto_o    <= 1'b0;
        end else begin
            err_proto_o <= err_proto_o | proto_hit;
            if (state == ARB_IDLE) begin
                wd_cnt_r <= '0;
            end else begin
                wd_cnt_r <= wd_next;
                if (wd_hit) begin
                    err_timeout_o <= 1'b1;
                end
            end

            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_onehot_o <= pick_onehot;
                        grant_id_o     <= pick_id;
                        grant_val_o    <= 1'b1;
                        aw_open_o      <= 1'b1;
                        w_open_o       <= 1'b1;
                        state          <= ARB_ADDR;
                    end
                end
                // AW and W may finish in either order or together.
                ARB_ADDR: begin
                    aw_done_r <= aw_done_nxt;
                    w_done_r  <= w_done_nxt;
                    aw_open_o <= !aw_done_nxt;
                    w_open_o  <= !w_done_nxt;
                    if (aw_done_nxt && w_done_nxt) begin
                        b_open_o <= 1'b1;
                        state    <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (b_hs_i) begin
                        ptr_r          <= grant_id_o;
                        grant_onehot_o <= '0;
                        grant_id_o     <= '0;
                        grant_val_o    <= 1'b0;
                        b_open_o       <= 1'b0;
                        aw_done_r      <= 1'b0;
                        w_done_r       <= 1'b0;
                        state          <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_liteic_slave_write_arbiter.sv
// Directed bench for liteic_slave_write_arbiter; grant order goes through a scoreboard
// queue that a negedge monitor drains whenever a new grant appears.
module tb_liteic_slave_write_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ID_WIDTH = 2;

    logic                clk_i = 1'b0;
    logic                rstn_i;
    logic [NUM_REQ-1:0]  req_i;
    logic                aw_hs_i;
    logic                w_hs_i;
    logic                b_hs_i;
    logic [NUM_REQ-1:0]  grant_onehot_o;
    logic [ID_WIDTH-1:0] grant_id_o;
    logic                grant_val_o;
    logic                aw_open_o;
    logic                w_open_o;
    logic                b_open_o;
    logic                err_timeout_o;
    logic                err_proto_o;

    int   pass_cnt  = 0;
    int   check_cnt = 0;
    int   exp_q[$];
    int   mon_exp;
    logic prev_val  = 1'b0;

    liteic_slave_write_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .req_i          (req_i),
        .aw_hs_i        (aw_hs_i),
        .w_hs_i         (w_hs_i),
        .b_hs_i         (b_hs_i),
        .grant_onehot_o (grant_onehot_o),
        .grant_id_o     (grant_id_o),
        .grant_val_o    (grant_val_o),
        .aw_open_o      (aw_open_o),
        .w_open_o       (w_open_o),
        .b_open_o       (b_open_o),
        .err_timeout_o  (err_timeout_o),
        .err_proto_o    (err_proto_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input logic aw, input logic w, input logic b);
        req_i   = req;
        aw_hs_i = aw;
        w_hs_i  = w;
        b_hs_i  = b;
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Starting in ADDR: AW and W in the same cycle, then B on the next.
    task automatic complete_write(input logic [NUM_REQ-1:0] req);
        applyStimulus(req, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("same_cycle_resp", b_open_o, 1);
        checkOutput("addr_closed", {aw_open_o, w_open_o}, 0);
        applyStimulus(req, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(req, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_after_b", grant_val_o, 0);
    endtask

    // Each rising grant must match the next owner the stimulus predicted.
    always @(negedge clk_i) begin
        if (grant_val_o === 1'b1 && prev_val !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("[TB] FAIL unexpected_grant: got id %0d, expected no grant", grant_id_o);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("grant_id", grant_id_o, mon_exp);
                checkOutput("grant_onehot", grant_onehot_o, 1 << mon_exp);
            end
        end
        prev_val = grant_val_o;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rstn_i = 1'b0;
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            step();
            checkOutput("reset_grant_val", grant_val_o, 0);
            checkOutput("reset_onehot", grant_onehot_o, 0);
            checkOutput("reset_opens", {aw_open_o, w_open_o, b_open_o}, 0);
            checkOutput("reset_errs", {err_timeout_o, err_proto_o}, 0);
        end
        exp_q.push_back(0);
        rstn_i = 1'b1;
        step();
        checkOutput("release_grant_val", grant_val_o, 1);
        checkOutput("release_grant_id", grant_id_o, 0);
        checkOutput("release_aw_open", aw_open_o, 1);

        // Fairness with every master requesting
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int k = 0; k < 4; k++) begin
            complete_write(4'b1111);
            step();
            checkOutput("turnaround_val", grant_val_o, 1);
        end

        // W well before AW on the grant to master 0, requests dropped meanwhile
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        step();
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("w_open_before_w", w_open_o, 1);
        step();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("w_closed_after_w", w_open_o, 0);
        checkOutput("aw_still_open", aw_open_o, 1);
        checkOutput("held_after_drop", grant_val_o, 1);
        step();
        step();
        checkOutput("no_resp_before_aw", b_open_o, 0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("resp_at_cycle6", b_open_o, 1);
        checkOutput("aw_closed_in_resp", aw_open_o, 0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_after_ordered", grant_val_o, 0);

        // Sparse requests around the rotating pointer
        exp_q.push_back(1);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("sparse_grant1_val", grant_val_o, 1);
        complete_write(4'b0000);
        exp_q.push_back(0);
        applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("drop_held_val", grant_val_o, 1);
        checkOutput("drop_held_id", grant_id_o, 0);
        complete_write(4'b0000);
        exp_q.push_back(1);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        step();
        complete_write(4'b0000);

        // Watchdog with B withheld
        exp_q.push_back(2);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (6) step();
        checkOutput("wd_cycle7", err_timeout_o, 0);
        step();
        checkOutput("wd_cycle8", err_timeout_o, 1);
        checkOutput("wd_b_open", b_open_o, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_b_completes", grant_val_o, 0);
        checkOutput("wd_sticky", err_timeout_o, 1);
        checkOutput("no_proto_yet", err_proto_o, 0);

        // Stray B in ADDR, then reset during RESP
        exp_q.push_back(3);
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("proto_set", err_proto_o, 1);
        checkOutput("proto_grant_kept", grant_id_o, 3);
        checkOutput("proto_opens", {aw_open_o, w_open_o, b_open_o}, 3'b110);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("proto_then_resp", b_open_o, 1);
        rstn_i = 1'b0;
        step();
        checkOutput("midreset_val", grant_val_o, 0);
        checkOutput("midreset_b_open", b_open_o, 0);
        checkOutput("midreset_flags", {err_timeout_o, err_proto_o}, 0);
        rstn_i = 1'b1;
        step();
        checkOutput("post_reset_idle", grant_val_o, 0);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
